gemm_psum_drain: RTL and testbench

GEMM_PSUM_DRAIN -- requirements
Module: gemm_psum_drain

---
 rtl/gemm_psum_drain_if.sv | 26 ++
 rtl/gemm_psum_drain.sv | 117 +++++++++++
 tb/tb_gemm_psum_drain.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_psum_drain_if.sv
// Bundle of the partial-sum drain ports: skewed column inputs from the array,
// aligned row output with valid/ready, and feeder backpressure/status.
interface gemm_psum_drain_if #(
  parameter int N          = 4,
  parameter int P_BITWIDTH = 24
);
  logic [N-1:0]            psum_valid;
  logic [N*P_BITWIDTH-1:0] psum_in;
  logic [15:0]             cfg_rows;
  logic                    out_valid;
  logic                    out_ready;
  logic [N*P_BITWIDTH-1:0] out_data;
  logic                    out_last;
  logic                    drain_full;
  logic                    overflow_err;

  modport master (
    output psum_valid, psum_in, cfg_rows, out_ready,
    input  out_valid, out_data, out_last, drain_full, overflow_err
  );

  modport slave (
    input  psum_valid, psum_in, cfg_rows, out_ready,
    output out_valid, out_data, out_last, drain_full, overflow_err
  );
endinterface

// File: rtl/gemm_psum_drain.sv
// Deskews the bottom-row partial sums of a systolic array through per-column
// FIFOs and emits aligned rows with tile-end marking and feeder backpressure.
module gemm_psum_drain #(
  parameter int N          = 4,
  parameter int P_BITWIDTH = 24,
  parameter int DEPTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  gemm_psum_drain_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] DRAIN_CNT = CW'(DEPTH - N);

  logic signed [P_BITWIDTH-1:0] mem [N][DEPTH];
  logic [AW-1:0] wr_ptr [N];
  logic [AW-1:0] rd_ptr [N];
  logic [CW-1:0] count  [N];
  logic [N-1:0]  not_empty;
  logic [N-1:0]  full;
  logic [N-1:0]  push;
  logic [N-1:0]  drop;
  logic          pop;

  logic signed [P_BITWIDTH-1:0] row_p1 [N];
  logic          vld_p1;
  logic          last_p1;
  logic          ovf;
  logic [15:0]   row_cnt;

  always_comb begin
    not_empty = '0;
    full      = '0;
    push      = '0;
    drop      = '0;
    for (int j = 0; j < N; j++) begin
      not_empty[j] = (count[j] != '0);
      full[j]      = (count[j] == FULL_CNT);
    end
    // A full FIFO may still accept a word when the same edge pops a row.
    for (int j = 0; j < N; j++) begin
      push[j] = bus.psum_valid[j] && (!full[j] || pop);
      drop[j] = bus.psum_valid[j] && full[j] && !pop;
    end
  end

  assign pop = (&not_empty) && (!vld_p1 || bus.out_ready);

  // ---- stage p0: column FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      if (push[j] && !rst)
        mem[j][wr_ptr[j]] <= $signed(bus.psum_in[j*P_BITWIDTH +: P_BITWIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        wr_ptr[j] <= '0;
        rd_ptr[j] <= '0;
        count[j]  <= '0;
      end
      ovf <= 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (push[j])
          wr_ptr[j] <= wr_ptr[j] + 1'b1;
        if (pop)
          rd_ptr[j] <= rd_ptr[j] + 1'b1;
        case ({push[j], pop})
          2'b10:   count[j] <= count[j] + 1'b1;
          2'b01:   count[j] <= count[j] - 1'b1;
          default: count[j] <= count[j];
        endcase
      end
      if (|drop)
        ovf <= 1'b1;
    end
  end

  // ---- stage p1: aligned output row register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      row_cnt <= '0;
      for (int j = 0; j < N; j++)
        row_p1[j] <= '0;
    end else if (pop) begin
      vld_p1 <= 1'b1;
      for (int j = 0; j < N; j++)
        row_p1[j] <= mem[j][rd_ptr[j]];
      if (row_cnt == bus.cfg_rows - 16'd1) begin
        last_p1 <= 1'b1;
        row_cnt <= '0;
      end else begin
        last_p1 <= 1'b0;
        row_cnt <= row_cnt + 16'd1;
      end
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_pack
    assign bus.out_data[j*P_BITWIDTH +: P_BITWIDTH] = row_p1[j];
  end

  assign bus.out_valid    = vld_p1;
  assign bus.out_last     = last_p1;
  assign bus.overflow_err = ovf;
  // Threshold leaves N cycles of margin for rows already launched into the array.
  assign bus.drain_full   = (count[0] >= DRAIN_CNT);
endmodule

// File: tb/tb_gemm_psum_drain.sv
// Directed bench for gemm_psum_drain: skewed feeds, stall/hold, backpressure,
// overflow, sign preservation and mid-tile reset, checked against a row queue.
module tb_gemm_psum_drain;
  localparam int N     = 4;
  localparam int P     = 24;
  localparam int DEPTH = 8;
  localparam int W     = N * P;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gemm_psum_drain_if #(.N(N), .P_BITWIDTH(P)) bus ();

  gemm_psum_drain #(.N(N), .P_BITWIDTH(P), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t         sb [$];
  int           checks    = 0;
  int           failures  = 0;
  int           model_cnt = 0;
  logic [W-1:0] rows [16];
  logic [P-1:0] c2 [9];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference tile counter: marks the expected last row of each tile.
  task automatic push_exp(input logic [W-1:0] d);
    exp_t e;
    e.data = d;
    e.last = (model_cnt == int'(bus.cfg_rows) - 1);
    model_cnt = e.last ? 0 : model_cnt + 1;
    sb.push_back(e);
  endtask

  // Column j carries row r at cycle r+j, as the array delivers it.
  task automatic feed(input int nrows);
    for (int r = 0; r < nrows; r++)
      push_exp(rows[r]);
    for (int c = 0; c < nrows + N - 1; c++) begin
      for (int j = 0; j < N; j++) begin
        int r = c - j;
        bus.psum_valid[j] = (r >= 0 && r < nrows);
        bus.psum_in[j*P +: P] = (r >= 0 && r < nrows) ? rows[r][j*P +: P] : '0;
      end
      tick();
    end
    bus.psum_valid = '0;
  endtask

  task automatic wait_empty(input string tag, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL %s observed=%0d pending rows expected=0", tag, sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    model_cnt = 0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=%0h expected=no_row", bus.out_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("row_data", bus.out_data, e.data);
        chk("row_last", W'(bus.out_last), W'(e.last));
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.psum_valid = '0;
    bus.psum_in    = '0;
    bus.cfg_rows   = 16'd2;
    bus.out_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_last", W'(bus.out_last), W'(0));
    chk("rst_drain_full", W'(bus.drain_full), W'(0));
    chk("rst_overflow", W'(bus.overflow_err), W'(0));

    // Basic two-row tile with exact latency
    tick();
    bus.cfg_rows  = 16'd2;
    bus.out_ready = 1'b1;
    for (int j = 0; j < N; j++) begin
      rows[0][j*P +: P] = P'(10 + j);
      rows[1][j*P +: P] = P'(20 + j);
    end
    feed(2);
    @(negedge clk);
    chk("lat_valid", W'(bus.out_valid), W'(1));
    chk("lat_row0", bus.out_data, rows[0]);
    chk("lat_last0", W'(bus.out_last), W'(0));
    tick();
    @(negedge clk);
    chk("row1_valid", W'(bus.out_valid), W'(1));
    chk("row1_last", W'(bus.out_last), W'(1));
    wait_empty("basic_drain", 20);

    // Consumer stall: first row held, then rows in order on consecutive cycles
    bus.out_ready = 1'b0;
    for (int r = 0; r < 2; r++)
      rows[r] = {$urandom, $urandom, $urandom};
    feed(2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", W'(bus.out_valid), W'(1));
      chk("hold_data", bus.out_data, rows[0]);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_row0", bus.out_data, rows[0]);
    tick();
    @(negedge clk);
    chk("release_row1_valid", W'(bus.out_valid), W'(1));
    chk("release_row1", bus.out_data, rows[1]);
    chk("release_row1_last", W'(bus.out_last), W'(1));
    wait_empty("stall_drain", 20);

    // Backpressure threshold on column 0
    bus.cfg_rows  = 16'd5;
    bus.out_ready = 1'b0;
    for (int r = 0; r < 5; r++)
      rows[r] = {$urandom, $urandom, $urandom};
    feed(5);
    @(negedge clk);
    chk("drain_full_set", W'(bus.drain_full), W'(1));
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain_full_before_pop", W'(bus.drain_full), W'(1));
    tick();
    @(negedge clk);
    chk("drain_full_clear", W'(bus.drain_full), W'(0));
    chk("after_pop_row1", bus.out_data, rows[1]);
    wait_empty("backpressure_drain", 30);

    // Overflow on column 2, then prove the dropped word never appears
    do_reset();
    bus.cfg_rows  = 16'd9;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 9; k++)
      c2[k] = P'($urandom);
    for (int k = 0; k < 9; k++) begin
      bus.psum_valid = 4'b0100;
      bus.psum_in    = '0;
      bus.psum_in[2*P +: P] = c2[k];
      tick();
      if (k == 7) begin
        bus.psum_valid = '0;
        @(negedge clk);
        chk("ovf_not_yet", W'(bus.overflow_err), W'(0));
      end
    end
    bus.psum_valid = '0;
    @(negedge clk);
    chk("ovf_set", W'(bus.overflow_err), W'(1));
    tick();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rows[k] = {$urandom, $urandom, $urandom};
      if (k < 8)
        rows[k][2*P +: P] = c2[k];
      push_exp(rows[k]);
    end
    for (int k = 0; k < 9; k++) begin
      bus.psum_in    = rows[k];
      bus.psum_valid = (k < 8) ? 4'b1011 : 4'b1111;
      tick();
    end
    bus.psum_valid = '0;
    wait_empty("ovf_drain", 30);
    chk("ovf_sticky", W'(bus.overflow_err), W'(1));
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", W'(bus.overflow_err), W'(0));
    tick();

    // Most negative value passes through untouched
    bus.cfg_rows  = 16'd1;
    bus.out_ready = 1'b1;
    rows[0] = {$urandom, $urandom, $urandom};
    rows[0][P-1:0] = 24'h800000;
    feed(1);
    tick();
    @(negedge clk);
    chk("neg_valid", W'(bus.out_valid), W'(1));
    chk("neg_col0", W'(bus.out_data[P-1:0]), W'(24'h800000));
    chk("neg_last", W'(bus.out_last), W'(1));
    wait_empty("neg_drain", 20);

    // Reset mid-tile with rows buffered, junk presented during reset
    bus.cfg_rows  = 16'd3;
    bus.out_ready = 1'b0;
    for (int r = 0; r < 4; r++)
      rows[r] = {$urandom, $urandom, $urandom};
    feed(4);
    @(negedge clk);
    chk("pre_rst_valid", W'(bus.out_valid), W'(1));
    tick();
    rst            = 1'b1;
    bus.psum_valid = '1;
    bus.psum_in    = {$urandom, $urandom, $urandom};
    tick();
    rst            = 1'b0;
    bus.psum_valid = '0;
    sb.delete();
    model_cnt = 0;
    @(negedge clk);
    chk("mid_rst_valid", W'(bus.out_valid), W'(0));
    chk("mid_rst_data", bus.out_data, '0);
    chk("mid_rst_drain_full", W'(bus.drain_full), W'(0));
    tick();
    bus.cfg_rows  = 16'd2;
    bus.out_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      rows[r] = {$urandom, $urandom, $urandom};
    feed(2);
    @(negedge clk);
    chk("new_tile_row0_last", W'(bus.out_last), W'(0));
    wait_empty("new_tile_drain", 20);
    tick();
    tick();
    @(negedge clk);
    chk("idle_end_valid", W'(bus.out_valid), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
